// File: rtl/minterm_response_checker.sv
// Response checker for a 4-input minterm block: compares each accepted sample
// against a golden truth table and produces a registered verdict after NUM_VEC samples.
module minterm_response_checker #(
  parameter logic [15:0] MINTERM_MASK = 16'h030B,
  parameter int unsigned NUM_VEC      = 5,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [3:0]       in_a,
  input  logic             in_q,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             fail_seen,
  output logic [3:0]       first_fail_a,
  output logic             first_fail_q,
  output logic [15:0]      seen_mask
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VEC - 1);

  logic [1:0] state;
  logic       accept;
  logic       expected;
  logic       mismatch;

  assign accept   = (state == RUN) && in_valid && !start;
  assign expected = MINTERM_MASK[in_a];
  // Case-inequality so an X/Z response is always counted as a failure.
  assign mismatch = (in_q !== expected);

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign pass = done && (err_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      vec_cnt      <= '0;
      err_cnt      <= '0;
      fail_seen    <= 1'b0;
      first_fail_a <= '0;
      first_fail_q <= 1'b0;
      seen_mask    <= '0;
    end else if (start) begin
      state        <= RUN;
      vec_cnt      <= '0;
      err_cnt      <= '0;
      fail_seen    <= 1'b0;
      first_fail_a <= '0;
      first_fail_q <= 1'b0;
      seen_mask    <= '0;
    end else if (accept) begin
      vec_cnt         <= vec_cnt + 1'b1;
      seen_mask[in_a] <= 1'b1;
      if (mismatch) begin
        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        fail_seen <= 1'b1;
        if (!fail_seen) begin
          first_fail_a <= in_a;
          first_fail_q <= in_q;
        end
      end
      if (vec_cnt == LAST_IDX) state <= DONE;
    end
  end

endmodule

// File: tb/tb_minterm_response_checker.sv
// Bench for minterm_response_checker: directed vector tables, hand sequences and
// randomized traffic checked against a sample-list reference model.
module tb_minterm_response_checker;

  localparam logic [15:0] MASK = 16'h030B;
  localparam int unsigned NV   = 5;

  logic clk = 1'b0;
  logic rst, start, in_valid, in_q;
  logic [3:0] in_a;
  logic busy, done, pass, fail_seen, first_fail_q;
  logic [7:0] vec_cnt, err_cnt;
  logic [3:0] first_fail_a;
  logic [15:0] seen_mask;

  logic s_start, s_valid, s_q;
  logic [3:0] s_a;
  logic s_busy, s_done, s_pass, s_fail_seen, s_ffq;
  logic [1:0] s_vec, s_err;
  logic [3:0] s_ffa;
  logic [15:0] s_seen;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  minterm_response_checker #(.MINTERM_MASK(MASK), .NUM_VEC(NV), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_a(in_a), .in_q(in_q),
    .busy(busy), .done(done), .pass(pass), .vec_cnt(vec_cnt), .err_cnt(err_cnt),
    .fail_seen(fail_seen), .first_fail_a(first_fail_a), .first_fail_q(first_fail_q),
    .seen_mask(seen_mask)
  );

  minterm_response_checker #(.MINTERM_MASK(~MASK), .NUM_VEC(3), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .start(s_start), .in_valid(s_valid), .in_a(s_a), .in_q(s_q),
    .busy(s_busy), .done(s_done), .pass(s_pass), .vec_cnt(s_vec), .err_cnt(s_err),
    .fail_seen(s_fail_seen), .first_fail_a(s_ffa), .first_fail_q(s_ffq),
    .seen_mask(s_seen)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Reference model: the run is just the list of accepted samples.
  typedef struct packed { logic [3:0] a; logic q; } samp_t;
  samp_t mq[$];
  bit m_run = 0, m_done = 0;

  task automatic model_reset();
    mq.delete(); m_run = 0; m_done = 0;
  endtask

  task automatic model_edge(input bit st, input bit v, input logic [3:0] a, input logic q);
    if (st) begin
      mq.delete(); m_run = 1; m_done = 0;
    end else if (m_run && v) begin
      mq.push_back('{a: a, q: q});
      if (mq.size() == NV) begin m_run = 0; m_done = 1; end
    end
  endtask

  task automatic model_check(input string tag);
    int errs = 0;
    logic [15:0] seen = '0;
    logic [3:0] fa = '0;
    logic fq = 1'b0;
    foreach (mq[i]) begin
      seen[mq[i].a] = 1'b1;
      if (mq[i].q !== MASK[mq[i].a]) begin
        if (errs == 0) begin fa = mq[i].a; fq = mq[i].q; end
        errs++;
      end
    end
    if (errs > 255) errs = 255;
    chk({tag, ".busy"}, 32'(busy), 32'(m_run));
    chk({tag, ".done"}, 32'(done), 32'(m_done));
    chk({tag, ".pass"}, 32'(pass), 32'(m_done && errs == 0));
    chk({tag, ".vec_cnt"}, 32'(vec_cnt), 32'(mq.size()));
    chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(errs));
    chk({tag, ".fail_seen"}, 32'(fail_seen), 32'(errs != 0));
    chk({tag, ".first_fail_a"}, 32'(first_fail_a), 32'(fa));
    chk({tag, ".first_fail_q"}, 32'(first_fail_q), 32'(fq));
    chk({tag, ".seen_mask"}, 32'(seen_mask), 32'(seen));
  endtask

  task automatic step(input string tag, input bit st, input bit v, input logic [3:0] a, input logic q);
    start = st; in_valid = v; in_a = a; in_q = q;
    @(posedge clk);
    model_edge(st, v, a, q);
    #1;
    model_check(tag);
    start = 1'b0; in_valid = 1'b0;
  endtask

  typedef struct packed {
    bit st; bit v; logic [3:0] a; logic q;
    bit e_done; bit e_pass; logic [7:0] e_vec; logic [7:0] e_err; logic [15:0] e_seen;
  } vec_t;
  vec_t tbl[$];

  task automatic run_table(input string tag, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      step(tag, tbl[i].st, tbl[i].v, tbl[i].a, tbl[i].q);
      chk({tag, ".tbl_done"}, 32'(done), 32'(tbl[i].e_done));
      chk({tag, ".tbl_pass"}, 32'(pass), 32'(tbl[i].e_pass));
      chk({tag, ".tbl_vec"}, 32'(vec_cnt), 32'(tbl[i].e_vec));
      chk({tag, ".tbl_err"}, 32'(err_cnt), 32'(tbl[i].e_err));
      chk({tag, ".tbl_seen"}, 32'(seen_mask), 32'(tbl[i].e_seen));
    end
  endtask

  task automatic sat_step(input logic [3:0] a, input logic q);
    s_valid = 1'b1; s_a = a; s_q = q;
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_a = '0; in_q = 1'b0;
    s_start = 1'b0; s_valid = 1'b0; s_a = '0; s_q = 1'b0;

    // golden run: rows 0..6
    tbl.push_back('{1,0,4'd0,0, 0,0,8'd0,8'd0,16'h0000});
    tbl.push_back('{0,1,4'd0,1, 0,0,8'd1,8'd0,16'h0001});
    tbl.push_back('{0,1,4'd1,1, 0,0,8'd2,8'd0,16'h0003});
    tbl.push_back('{0,1,4'd2,0, 0,0,8'd3,8'd0,16'h0007});
    tbl.push_back('{0,1,4'd3,1, 0,0,8'd4,8'd0,16'h000F});
    tbl.push_back('{0,1,4'd8,1, 1,1,8'd5,8'd0,16'h010F});
    tbl.push_back('{0,1,4'd5,1, 1,1,8'd5,8'd0,16'h010F});
    // single fault at A=2: rows 7..12
    tbl.push_back('{1,0,4'd0,0, 0,0,8'd0,8'd0,16'h0000});
    tbl.push_back('{0,1,4'd0,1, 0,0,8'd1,8'd0,16'h0001});
    tbl.push_back('{0,1,4'd1,1, 0,0,8'd2,8'd0,16'h0003});
    tbl.push_back('{0,1,4'd2,1, 0,0,8'd3,8'd1,16'h0007});
    tbl.push_back('{0,1,4'd3,1, 0,0,8'd4,8'd1,16'h000F});
    tbl.push_back('{0,1,4'd8,1, 1,0,8'd5,8'd1,16'h010F});
    // two faults (A=2 Q=1, A=8 Q=0): rows 13..18
    tbl.push_back('{1,0,4'd0,0, 0,0,8'd0,8'd0,16'h0000});
    tbl.push_back('{0,1,4'd0,1, 0,0,8'd1,8'd0,16'h0001});
    tbl.push_back('{0,1,4'd1,1, 0,0,8'd2,8'd0,16'h0003});
    tbl.push_back('{0,1,4'd2,1, 0,0,8'd3,8'd1,16'h0007});
    tbl.push_back('{0,1,4'd3,1, 0,0,8'd4,8'd1,16'h000F});
    tbl.push_back('{0,1,4'd8,0, 1,0,8'd5,8'd2,16'h010F});

    #1;
    model_check("reset");
    @(negedge clk); rst = 1'b0;

    step("idle_valid", 0, 1, 4'd3, 1'b1);
    run_table("golden", 0, 6);
    run_table("fault1", 7, 12);
    chk("fault1.ffa", 32'(first_fail_a), 32'd2);
    chk("fault1.ffq", 32'(first_fail_q), 32'd1);
    run_table("fault2", 13, 18);
    chk("fault2.ffa", 32'(first_fail_a), 32'd2);
    chk("fault2.ffq", 32'(first_fail_q), 32'd1);
    step("done_valid", 0, 1, 4'd2, 1'b1);

    // gap of three idle cycles delays done by three cycles
    step("gap", 1, 0, 4'd0, 1'b0);
    step("gap", 0, 1, 4'd0, 1'b1);
    step("gap", 0, 1, 4'd1, 1'b1);
    for (int i = 0; i < 3; i++) step("gap_idle", 0, 0, 4'd9, 1'b0);
    step("gap", 0, 1, 4'd2, 1'b0);
    step("gap", 0, 1, 4'd3, 1'b1);
    chk("gap.not_done", 32'(done), 32'd0);
    step("gap", 0, 1, 4'd8, 1'b1);
    chk("gap.done", 32'(done), 32'd1);

    // reset mid-run after two samples: outputs clear before the next edge
    step("rstmid", 1, 0, 4'd0, 1'b0);
    step("rstmid", 0, 1, 4'd0, 1'b1);
    step("rstmid", 0, 1, 4'd2, 1'b1);
    #2 rst = 1'b1;
    #1 model_reset();
    model_check("rst_async");
    @(negedge clk); rst = 1'b0;
    run_table("post_rst", 0, 6);

    // restart after three samples, with a coincident valid sample dropped
    step("restart", 1, 0, 4'd0, 1'b0);
    step("restart", 0, 1, 4'd0, 1'b1);
    step("restart", 0, 1, 4'd1, 1'b1);
    step("restart", 0, 1, 4'd2, 1'b1);
    step("restart_hit", 1, 1, 4'd2, 1'b1);
    chk("restart.vec0", 32'(vec_cnt), 32'd0);
    chk("restart.seen0", 32'(seen_mask), 32'd0);
    for (int i = 0; i < 5; i++) step("restart_run", 0, 1, 4'(i), MASK[i]);
    chk("restart.done", 32'(done), 32'd1);
    chk("restart.pass", 32'(pass), 32'd1);

    // start coincident with the final sample: run restarts instead of finishing
    step("st_last", 1, 0, 4'd0, 1'b0);
    for (int i = 0; i < 4; i++) step("st_last", 0, 1, 4'(i), MASK[i]);
    step("st_last_hit", 1, 1, 4'd8, 1'b1);
    chk("st_last.busy", 32'(busy), 32'd1);
    chk("st_last.vec", 32'(vec_cnt), 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [3:0] a;
      bit st, v;
      a  = 4'($urandom_range(0, 15));
      st = ($urandom_range(0, 19) == 0);
      v  = ($urandom_range(0, 3) != 0);
      if (!m_run && !st && $urandom_range(0, 2) == 0) st = 1;
      step("rand", st, v, a, MASK[a] ^ ($urandom_range(0, 5) == 0));
    end

    // saturation: inverted mask, every sample fails, one response is X
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    chk("sat.busy", 32'(s_busy), 32'd1);
    sat_step(4'd0, 1'b1);
    sat_step(4'd1, 1'b1);
    chk("sat.err2", 32'(s_err), 32'd2);
    sat_step(4'd2, 1'bx);
    chk("sat.done", 32'(s_done), 32'd1);
    chk("sat.vec", 32'(s_vec), 32'd3);
    chk("sat.err", 32'(s_err), 32'd3);
    chk("sat.pass", 32'(s_pass), 32'd0);
    chk("sat.fail_seen", 32'(s_fail_seen), 32'd1);
    chk("sat.ffa", 32'(s_ffa), 32'd0);
    chk("sat.ffq", 32'(s_ffq), 32'd1);
    chk("sat.seen", 32'(s_seen), 32'h0007);
    sat_step(4'd3, 1'b0);
    chk("sat.hold", 32'(s_err), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
